elastic_fifo_demux: RTL and testbench

//  Single-clock elastic FIFO followed by a narrow-to-wide gearbox (1:RATIO demux).

---
 rtl/elastic_fifo_demux_pkg.sv | 13 +
 rtl/elastic_fifo_demux_if.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 63 ++++++
 rtl/elastic_fifo_demux.sv | 75 +++++++
 tb/tb_elastic_fifo_demux.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/elastic_fifo_demux_pkg.sv
// Shared defaults and width helpers for the elastic FIFO + narrow-to-wide gearbox.
package elastic_fifo_demux_pkg;

  localparam int unsigned DefWidthIn  = 4;
  localparam int unsigned DefWidthOut = 16;
  localparam int unsigned DefDepth    = 32;

  // Index width for a counter over v values; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/elastic_fifo_demux_if.sv
// Narrow write port and wide read port of the gearbox, grouped as one bundle.
interface elastic_fifo_demux_if #(
  parameter int unsigned WIDTH_IN  = 4,
  parameter int unsigned WIDTH_OUT = 16
) ();

  logic [WIDTH_IN-1:0]  i_data_in;
  logic                 i_write_en;
  logic                 i_ready_out;
  logic [WIDTH_OUT-1:0] o_data_out;
  logic                 o_valid_out;
  logic                 o_ready_in;

  modport slave (
    input  i_data_in,
    input  i_write_en,
    input  o_ready_in,
    output i_ready_out,
    output o_data_out,
    output o_valid_out
  );

  modport master (
    output i_data_in,
    output i_write_en,
    output o_ready_in,
    input  i_ready_out,
    input  o_data_out,
    input  o_valid_out
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is visible on dout_o while not empty.
module sync_fifo_fwft
  import elastic_fifo_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = idx_width(DEPTH);
  localparam logic [AW:0] CountFull = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/elastic_fifo_demux.sv
// Elastic FIFO feeding a 1:RATIO gearbox that packs narrow words LSB-first into one wide word.
module elastic_fifo_demux
  import elastic_fifo_demux_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = DefWidthIn,
  parameter int unsigned WIDTH_OUT = DefWidthOut,
  parameter int unsigned DEPTH     = DefDepth
) (
  input logic                 clk,
  input logic                 rst,
  elastic_fifo_demux_if.slave bus
);

  localparam int unsigned RATIO = WIDTH_OUT / WIDTH_IN;
  localparam int unsigned SlotW = idx_width(RATIO);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(RATIO - 1);

  logic [SlotW-1:0]     slot_q, slot_d;
  logic [WIDTH_OUT-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [WIDTH_IN-1:0]  fifo_dout;

  // A held wide word blocks further pops until it is consumed.
  assign fifo_pop = !fifo_empty && (!valid_q || bus.o_ready_in);

  sync_fifo_fwft #(
    .WIDTH (WIDTH_IN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.i_write_en),
    .din_i   (bus.i_data_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    slot_d  = slot_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && bus.o_ready_in) valid_d = 1'b0;
    if (fifo_pop) begin
      for (int unsigned s = 0; s < RATIO; s++) begin
        if (slot_q == SlotW'(s)) data_d[s*WIDTH_IN +: WIDTH_IN] = fifo_dout;
      end
      if (slot_q == SlotLast) begin
        slot_d  = '0;
        valid_d = 1'b1;
      end else begin
        slot_d = slot_q + SlotW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.i_ready_out = !fifo_full;
  assign bus.o_data_out  = data_q;
  assign bus.o_valid_out = valid_q;

endmodule

// File: tb/tb_elastic_fifo_demux.sv
// Directed bench for elastic_fifo_demux: reset, packing, backpressure, full and mid-run reset.
module tb_elastic_fifo_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;

  elastic_fifo_demux_if #(.WIDTH_IN(4), .WIDTH_OUT(16)) bus ();

  elastic_fifo_demux #(
    .WIDTH_IN  (4),
    .WIDTH_OUT (16),
    .DEPTH     (32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] cap_q [$];
  int          cap_cyc [$];

  // Words are consumed at the next rising edge; record them half a cycle early.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.o_valid_out && bus.o_ready_in) begin
      cap_q.push_back(bus.o_data_out);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [3:0] d);
    bus.i_data_in  = d;
    bus.i_write_en = 1'b1;
    tick(1);
    bus.i_write_en = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.i_write_en = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
  endtask

  logic [15:0] exp_full [9] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h3210,
                                16'h7654, 16'hBA98, 16'hFEDC, 16'h3210};

  initial begin
    bus.i_data_in  = '0;
    bus.i_write_en = 1'b0;
    bus.o_ready_in = 1'b1;

    // Reset
    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid_out), 32'd0);
    check("rst_data", 32'(bus.o_data_out), 32'h0);
    check("rst_ready", 32'(bus.i_ready_out), 32'd1);

    // Two packets at full rate
    clear_caps();
    write_word(4'hD);
    write_word(4'h9);
    write_word(4'h9);
    write_word(4'hB);
    @(negedge clk);
    check("lat_not_yet", 32'(bus.o_valid_out), 32'd0);
    tick(1);
    @(negedge clk);
    check("lat_valid", 32'(bus.o_valid_out), 32'd1);
    check("lat_data", 32'(bus.o_data_out), 32'hB99D);
    tick(1);
    @(negedge clk);
    check("pulse_clear", 32'(bus.o_valid_out), 32'd0);
    write_word(4'hC);
    write_word(4'h8);
    write_word(4'h8);
    write_word(4'hA);
    tick(8);
    check("pkt_count", 32'(cap_q.size()), 32'd2);
    check("pkt0", 32'(cap_q[0]), 32'hB99D);
    check("pkt1", 32'(cap_q[1]), 32'hA88C);

    // Backpressure with three packets queued
    do_reset();
    clear_caps();
    bus.o_ready_in = 1'b0;
    write_word(4'hD); write_word(4'h9); write_word(4'h9); write_word(4'hB);
    write_word(4'hC); write_word(4'h8); write_word(4'h8); write_word(4'hA);
    write_word(4'h0); write_word(4'h1); write_word(4'h2); write_word(4'h3);
    tick(3);
    @(negedge clk);
    check("bp_valid", 32'(bus.o_valid_out), 32'd1);
    check("bp_data", 32'(bus.o_data_out), 32'hB99D);
    check("bp_count", 32'(u_dut.u_fifo.count_q), 32'd8);
    tick(3);
    @(negedge clk);
    check("bp_stable", 32'(bus.o_data_out), 32'hB99D);
    check("bp_count_hold", 32'(u_dut.u_fifo.count_q), 32'd8);
    bus.o_ready_in = 1'b1;
    tick(16);
    check("bp_n", 32'(cap_q.size()), 32'd3);
    check("bp_w0", 32'(cap_q[0]), 32'hB99D);
    check("bp_w1", 32'(cap_q[1]), 32'hA88C);
    check("bp_w2", 32'(cap_q[2]), 32'h3210);
    check("bp_gap01", 32'(cap_cyc[1] - cap_cyc[0]), 32'd4);
    check("bp_gap12", 32'(cap_cyc[2] - cap_cyc[1]), 32'd4);

    // Fill to capacity: 4 packed + 32 buffered
    do_reset();
    clear_caps();
    bus.o_ready_in = 1'b0;
    for (int k = 0; k < 35; k++) write_word(4'(k));
    @(negedge clk);
    check("full_ready_35", 32'(bus.i_ready_out), 32'd1);
    write_word(4'(35));
    @(negedge clk);
    check("full_ready_36", 32'(bus.i_ready_out), 32'd0);
    check("full_count", 32'(u_dut.u_fifo.count_q), 32'd32);
    check("full_head", 32'(bus.o_data_out), 32'h3210);
    for (int k = 0; k < 4; k++) write_word(4'hF);
    @(negedge clk);
    check("full_drop", 32'(u_dut.u_fifo.count_q), 32'd32);
    bus.o_ready_in = 1'b1;
    tick(44);
    check("full_n", 32'(cap_q.size()), 32'd9);
    for (int j = 0; j < 9; j++) check($sformatf("full_w%0d", j), 32'(cap_q[j]), 32'(exp_full[j]));
    check("full_empty", 32'(u_dut.u_fifo.count_q), 32'd0);

    // Mid-run reset discards partial data and writes made during reset
    clear_caps();
    write_word(4'h1);
    write_word(4'h2);
    rst            = 1'b1;
    bus.i_data_in  = 4'hE;
    bus.i_write_en = 1'b1;
    tick(1);
    rst            = 1'b0;
    bus.i_write_en = 1'b0;
    @(negedge clk);
    check("mid_count", 32'(u_dut.u_fifo.count_q), 32'd0);
    write_word(4'h5);
    write_word(4'h6);
    write_word(4'h7);
    write_word(4'h8);
    tick(4);
    check("mid_n", 32'(cap_q.size()), 32'd1);
    check("mid_w0", 32'(cap_q[0]), 32'h8765);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
